// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Package : uart_pkg
// Purpose : Shared frame layout constants, output-stage state type and the
//           frame builder used by the UART transmit framer.
// Revision: 1.0  initial release
// ============================================================================
package uart_pkg;

  localparam int FRAME_W   = 11;
  localparam int BIT_START = 0;
  localparam int BIT_PAR   = 9;
  localparam int BIT_STOP  = 10;
  localparam int DATA_LSB  = 1;
  localparam int DATA_W    = 8;

  // Idle UART line is all ones; used whenever no frame is presented.
  localparam logic [FRAME_W-1:0] LINE_IDLE = 11'h7FF;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } out_state_t;

  // frame = {stop, par, data[7:0], start}. With parity disabled bit9 acts
  // as a second stop bit.
  function automatic logic [FRAME_W-1:0] build_frame(
    input logic [DATA_W-1:0] data,
    input logic              par_en,
    input logic              par_odd
  );
    logic [FRAME_W-1:0] f;
    logic               par;
    par                    = par_en ? ((^data) ^ par_odd) : 1'b1;
    f                      = LINE_IDLE;
    f[BIT_START]           = 1'b0;
    f[DATA_LSB +: DATA_W]  = data;
    f[BIT_PAR]             = par;
    f[BIT_STOP]            = 1'b1;
    return f;
  endfunction

endpackage : uart_pkg
`default_nettype wire

// File: rtl/uart_byte_fifo.sv
`default_nettype none
// ============================================================================
// Module  : uart_byte_fifo
// Purpose : Synchronous FIFO with a registered "ready" (not full) flag.
// Ports   : clk, rst_n      clock, async active-low reset
//           i_push, i_data  write request / data (ignored when o_ready=0)
//           o_ready         registered !full, low during reset
//           i_pop, o_data   read request / head data (ignored when empty)
//           o_empty, o_full status flags derived from the count
//           o_count         number of entries held
// Revision: 1.0  initial release
// ============================================================================
module uart_byte_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_data,
  output logic                     o_ready,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_data,
  output logic                     o_empty,
  output logic                     o_full,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] C_FULL = CW'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             r_ready;

  logic             w_push;
  logic             w_pop;
  logic [CW-1:0]    w_count_next;

  // Pushes are gated by the registered ready so the count can never exceed
  // DEPTH, even if a producer ignores the handshake.
  assign w_push = i_push && r_ready;
  assign w_pop  = i_pop && (r_count != '0);

  always_comb begin
    w_count_next = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_next = r_count + 1'b1;
      2'b01:   w_count_next = r_count - 1'b1;
      default: w_count_next = r_count;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_ready  <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= w_count_next;
      // Ready follows the post-edge count, so a pop while full reopens the
      // input only on the following cycle.
      r_ready <= (w_count_next != C_FULL);
    end
  end

  // Storage needs no reset: entries are only read after being written.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_data;
  end

  assign o_data  = r_mem[r_rd_ptr];
  assign o_ready = r_ready;
  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == C_FULL);
  assign o_count = r_count;

endmodule : uart_byte_fifo
`default_nettype wire

// File: rtl/uart_tx_framer.sv
`default_nettype none
// ============================================================================
// Module  : uart_tx_framer
// Purpose : Buffers bytes from a valid/ready producer and presents complete
//           11-bit UART frames to the transmitter one at a time.
// Ports   : clk, rst_n               clock, async active-low reset
//           in_data/in_valid/in_ready byte input handshake
//           frame/frame_valid/frame_ready  frame output handshake
//           fifo_count                bytes in the FIFO (not the frame reg)
// Revision: 1.0  initial release
// ============================================================================
module uart_tx_framer
  import uart_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int PARITY_EN  = 1,
  parameter int PARITY_ODD = 0
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [7:0]                  in_data,
  input  logic                        in_valid,
  output logic                        in_ready,
  output logic [10:0]                 frame,
  output logic                        frame_valid,
  input  logic                        frame_ready,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

  out_state_t         r_state;
  out_state_t         w_state_next;
  logic [FRAME_W-1:0] r_frame;

  logic               w_fifo_ready;
  logic               w_fifo_empty;
  logic               w_fifo_full;
  logic [DATA_W-1:0]  w_fifo_data;
  logic               w_pop;
  logic               w_frame_taken;

  uart_byte_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_W)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (in_valid),
    .i_data  (in_data),
    .o_ready (w_fifo_ready),
    .i_pop   (w_pop),
    .o_data  (w_fifo_data),
    .o_empty (w_fifo_empty),
    .o_full  (w_fifo_full),
    .o_count (fifo_count)
  );

  // The output register is free when idle or when its frame leaves this
  // edge; either way it refills straight from the FIFO head.
  assign w_frame_taken = (r_state == ST_HOLD) && frame_ready;
  assign w_pop         = !w_fifo_empty && ((r_state == ST_IDLE) || frame_ready);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_next;
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: if (!w_fifo_empty)                w_state_next = ST_HOLD;
      ST_HOLD: if (frame_ready && w_fifo_empty)  w_state_next = ST_IDLE;
      default:                                   w_state_next = ST_IDLE;
    endcase
  end

  // Frame register: idle line whenever nothing is presented
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_frame <= LINE_IDLE;
    end else if (w_pop) begin
      r_frame <= build_frame(w_fifo_data, (PARITY_EN != 0), (PARITY_ODD != 0));
    end else if (w_frame_taken) begin
      r_frame <= LINE_IDLE;
    end
  end

  // Output decode
  always_comb begin
    frame_valid = (r_state == ST_HOLD);
  end

  assign frame    = r_frame;
  assign in_ready = w_fifo_ready;

  // Full flag is implied by in_ready; kept on the FIFO for other users.
  logic w_unused;
  assign w_unused = w_fifo_full;

endmodule : uart_tx_framer
`default_nettype wire

// File: tb/tb_uart_tx_framer.sv
`default_nettype none
// ============================================================================
// Module  : tb_uart_tx_framer
// Purpose : Directed self-checking bench for uart_tx_framer with a queue
//           based reference model and literal spot checks.
// Revision: 1.0  initial release
// ============================================================================
module tb_uart_tx_framer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_valid = 1'b0;
  logic        frame_ready = 1'b0;

  logic        in_ready, in_ready_odd, in_ready_np;
  logic [10:0] frame, frame_odd, frame_np;
  logic        frame_valid, frame_valid_odd, frame_valid_np;
  logic [2:0]  fifo_count, fifo_count_odd, fifo_count_np;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  uart_tx_framer #(.FIFO_DEPTH(4), .PARITY_EN(1), .PARITY_ODD(0)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .frame(frame), .frame_valid(frame_valid),
    .frame_ready(frame_ready), .fifo_count(fifo_count));

  uart_tx_framer #(.FIFO_DEPTH(4), .PARITY_EN(1), .PARITY_ODD(1)) dut_odd (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready_odd), .frame(frame_odd), .frame_valid(frame_valid_odd),
    .frame_ready(frame_ready), .fifo_count(fifo_count_odd));

  uart_tx_framer #(.FIFO_DEPTH(4), .PARITY_EN(0), .PARITY_ODD(0)) dut_np (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready_np), .frame(frame_np), .frame_valid(frame_valid_np),
    .frame_ready(frame_ready), .fifo_count(fifo_count_np));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    else n_pass++;
  endtask

  // ---------------- reference model ----------------
  function automatic logic [10:0] model_frame(input logic [7:0] d, input bit en, input bit odd);
    int ones = 0;
    logic par;
    for (int b = 0; b < 8; b++) ones += int'(d[b]);
    par = en ? logic'((ones % 2) ^ int'(odd)) : 1'b1;
    return {1'b1, par, d, 1'b0};
  endfunction

  logic [7:0] m_q[$];
  logic       m_valid = 1'b0;
  logic [7:0] m_data = 8'h00;
  logic       m_ready = 1'b0;
  logic       m_push;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_q.delete();
      m_valid = 1'b0;
      m_ready = 1'b0;
    end else begin
      m_push = in_valid && m_ready;
      // The presented frame is replaced unless it is waiting for the sink.
      if (!(m_valid && !frame_ready)) begin
        if (m_q.size() > 0) begin
          m_data  = m_q.pop_front();
          m_valid = 1'b1;
        end else begin
          m_valid = 1'b0;
        end
      end
      if (m_push) m_q.push_back(in_data);
      m_ready = (m_q.size() != 4);
    end
  end

  always @(negedge clk) begin
    check("in_ready",    32'(in_ready),    32'(m_ready));
    check("frame_valid", 32'(frame_valid), 32'(m_valid));
    check("fifo_count",  32'(fifo_count),  32'(m_q.size()));
    check("frame",       32'(frame),       32'(m_valid ? model_frame(m_data, 1, 0) : 11'h7FF));
    check("frame_odd",   32'(frame_odd),   32'(m_valid ? model_frame(m_data, 1, 1) : 11'h7FF));
    check("frame_np",    32'(frame_np),    32'(m_valid ? model_frame(m_data, 0, 0) : 11'h7FF));
  end

  // ---------------- directed stimulus ----------------
  task automatic idle_inputs();
    in_valid = 1'b0;
    in_data  = 8'($urandom);
  endtask

  initial begin
    idle_inputs();
    repeat (3) @(negedge clk);
    check("rst_frame", 32'(frame), 32'h7FF);
    check("rst_valid", 32'(frame_valid), 32'h0);
    check("rst_ready", 32'(in_ready), 32'h0);
    check("rst_count", 32'(fifo_count), 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_rst", 32'(in_ready), 32'h1);

    // Single byte, even parity, hold then take
    in_valid = 1'b1; in_data = 8'h55;
    @(negedge clk); idle_inputs();
    check("lat_not_yet", 32'(frame_valid), 32'h0);
    @(negedge clk);
    check("t1_frame", 32'(frame), 32'h4AA);
    check("t1_frame_odd", 32'(frame_odd), 32'h6AA);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t1_hold", 32'(frame), 32'h4AA);
    end
    frame_ready = 1'b1;
    @(negedge clk); frame_ready = 1'b0;
    check("t1_done_valid", 32'(frame_valid), 32'h0);
    check("t1_done_frame", 32'(frame), 32'h7FF);

    // Parity modes
    in_valid = 1'b1; in_data = 8'h07;
    @(negedge clk); idle_inputs();
    @(negedge clk);
    check("t2_even", 32'(frame), 32'h60E);
    check("t2_nopar", 32'(frame_np), 32'h60E);
    check("t2_odd", 32'(frame_odd), 32'h40E);
    frame_ready = 1'b1;
    @(negedge clk); frame_ready = 1'b0;

    // Fill with sink stalled
    for (int i = 1; i <= 6; i++) begin
      in_valid = 1'b1; in_data = 8'(i);
      @(negedge clk);
    end
    idle_inputs();
    check("t3_ready", 32'(in_ready), 32'h0);
    check("t3_count", 32'(fifo_count), 32'h4);
    check("t3_frame", 32'(frame), 32'h602);

    // Back-to-back drain
    frame_ready = 1'b1;
    for (int k = 2; k <= 5; k++) begin
      @(negedge clk);
      check("t4_order", 32'(frame[8:1]), 32'(k));
      check("t4_valid", 32'(frame_valid), 32'h1);
    end
    @(negedge clk);
    frame_ready = 1'b0;
    check("t4_end_valid", 32'(frame_valid), 32'h0);
    check("t4_end_count", 32'(fifo_count), 32'h0);

    // Simultaneous push/pop at count 2
    for (int i = 1; i <= 3; i++) begin
      in_valid = 1'b1; in_data = 8'(8'h11 * i);
      @(negedge clk);
    end
    check("t5_pre_count", 32'(fifo_count), 32'h2);
    in_valid = 1'b1; in_data = 8'h44; frame_ready = 1'b1;
    @(negedge clk);
    idle_inputs();
    check("t5_count", 32'(fifo_count), 32'h2);
    check("t5_frame", 32'(frame[8:1]), 32'h22);
    @(negedge clk);
    frame_ready = 1'b0;
    check("t5_next", 32'(frame[8:1]), 32'h33);
    in_valid = 1'b1; in_data = 8'h55;
    @(negedge clk);
    in_data = 8'h66;
    @(negedge clk);
    idle_inputs();
    check("t6_pre_count", 32'(fifo_count), 32'h3);

    // Asynchronous reset between edges
    #3 rst_n = 1'b0;
    #1;
    check("t6_frame", 32'(frame), 32'h7FF);
    check("t6_valid", 32'(frame_valid), 32'h0);
    check("t6_count", 32'(fifo_count), 32'h0);
    check("t6_ready", 32'(in_ready), 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    frame_ready = 1'b1;
    repeat (5) @(negedge clk);
    check("t6_nothing", 32'(frame_valid), 32'h0);
    frame_ready = 1'b0;

    // Still functional after reset
    in_valid = 1'b1; in_data = 8'hA5;
    @(negedge clk); idle_inputs();
    @(negedge clk);
    check("post_rst_frame", 32'(frame), 32'(model_frame(8'hA5, 1, 0)));
    check("post_rst_lit", 32'(frame), 32'h54A);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_uart_tx_framer
`default_nettype wire
